// File: rtl/instr_sequencer_if.sv
// Instruction-memory port between the sequencer (master) and the fetch memory (slave).
// Valid/ready request channel plus a response strobe carrying the fetched word.
interface instr_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;

    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM of the RV32I core: fetch, wait, execute, write-back.
// Owns PC, IR, retire counting and the sticky halt/trap stop states.
module instr_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    instr_sequencer_if.master imem,
    output logic [XLEN-1:0]   instr,
    input  logic              dec_reg_write,
    input  logic              dec_illegal,
    input  logic              halt_req,
    output logic              rf_we,
    output logic [XLEN-1:0]   pc,
    output logic              retire,
    output logic [31:0]       instr_count,
    output logic              halted,
    output logic              trap,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        StFetch = 3'd0,
        StWait  = 3'd1,
        StExec  = 3'd2,
        StWb    = 3'd3,
        StHalt  = 3'd4,
        StTrap  = 3'd5
    } state_e;

    localparam logic [XLEN-1:0] NopInstr = XLEN'(32'h0000_0013);

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] ir_q;
    logic [31:0]     count_q;
    logic            halted_q;
    logic            trap_q;
    logic            halt_pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            ir_q        <= NopInstr;
            count_q     <= 32'd0;
            halted_q    <= 1'b0;
            trap_q      <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            // A halt request seen outside WB is remembered until the next WB.
            if (halt_req && state_q != StWb) begin
                halt_pend_q <= 1'b1;
            end
            unique case (state_q)
                StFetch: begin
                    if (imem.req_ready) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (imem.rsp_valid) begin
                        ir_q    <= imem.rsp_data;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (dec_illegal) begin
                        trap_q  <= 1'b1;
                        state_q <= StTrap;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StWb: begin
                    pc_q        <= pc_q + XLEN'(4);
                    count_q     <= count_q + 32'd1;
                    halt_pend_q <= 1'b0;
                    if (halt_req || halt_pend_q) begin
                        halted_q <= 1'b1;
                        state_q  <= StHalt;
                    end else begin
                        state_q <= StFetch;
                    end
                end
                StHalt, StTrap: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= StFetch;
                end
            endcase
        end
    end

    assign imem.req_valid = (state_q == StFetch);
    assign imem.addr      = pc_q;

    // x0 is hardwired to zero, so a write to rd=0 is dropped here.
    assign rf_we       = (state_q == StWb) && dec_reg_write && (ir_q[11:7] != 5'd0);
    assign retire      = (state_q == StWb);
    assign instr       = ir_q;
    assign pc          = pc_q;
    assign instr_count = count_q;
    assign halted      = halted_q;
    assign trap        = trap_q;
    assign state       = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: random-latency memory, decoder stand-in, and a
// scoreboard of expected retirements checked by an independent monitor.
module tb_instr_sequencer;

    localparam logic [31:0] ResetPc = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dec_reg_write;
    logic        dec_illegal;
    logic        halt_req = 1'b0;
    logic [31:0] instr;
    logic        rf_we;
    logic [31:0] pc;
    logic        retire;
    logic [31:0] instr_count;
    logic        halted;
    logic        trap;
    logic [2:0]  state;

    instr_sequencer_if #(.XLEN(32)) imem_bus ();

    instr_sequencer #(
        .XLEN     (32),
        .RESET_PC (ResetPc)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imem_bus),
        .instr         (instr),
        .dec_reg_write (dec_reg_write),
        .dec_illegal   (dec_illegal),
        .halt_req      (halt_req),
        .rf_we         (rf_we),
        .pc            (pc),
        .retire        (retire),
        .instr_count   (instr_count),
        .halted        (halted),
        .trap          (trap),
        .state         (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Decoder stand-in: RV32I base opcodes are legal; stores and branches write no rd.
    function automatic logic legal_op(input logic [6:0] op);
        case (op)
            7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [31:0] w);
        return legal_op(w[6:0]) && w[6:0] != 7'h23 && w[6:0] != 7'h63;
    endfunction

    always_comb begin
        dec_illegal   = !legal_op(instr[6:0]);
        dec_reg_write = writes_rd(instr);
    end

    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w      = $urandom;
        w[6:0] = ops[$urandom_range(8)];
        if ($urandom_range(3) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic        rf_we;
        int          retire_cyc;
    } rec_t;

    rec_t        sb [$];
    logic [31:0] forced [$];
    int          max_ready_wait = 0;
    int          max_rsp_wait = 0;

    // Memory model state: next expected fetch address and pending trap.
    logic [31:0] model_pc = ResetPc;
    int          exp_trap_cyc = -1;
    logic [31:0] trap_addr = '0;
    bit          pending = 0;
    int          ready_wait = 0;
    int          rsp_wait = 0;
    logic [31:0] cur_word = '0;

    initial begin
        imem_bus.req_ready = 1'b0;
        imem_bus.rsp_valid = 1'b0;
        imem_bus.rsp_data  = '0;
    end

    always begin
        @(negedge clk);
        #1;
        imem_bus.req_ready = 1'b0;
        imem_bus.rsp_valid = 1'b0;
        if (rst) begin
            pending      = 0;
            ready_wait   = $urandom_range(max_ready_wait);
            model_pc     = ResetPc;
            exp_trap_cyc = -1;
            sb.delete();
        end else if (pending) begin
            check("no_extra_req", imem_bus.req_valid, 1'b0);
            if (rsp_wait == 0) begin
                imem_bus.rsp_valid = 1'b1;
                imem_bus.rsp_data  = cur_word;
                pending            = 0;
                if (!legal_op(cur_word[6:0])) begin
                    exp_trap_cyc = cyc + 2;
                    trap_addr    = model_pc;
                end else begin
                    sb.push_back('{addr: model_pc, word: cur_word,
                                   rf_we: writes_rd(cur_word) && cur_word[11:7] != 5'd0,
                                   retire_cyc: cyc + 2});
                    model_pc = model_pc + 32'd4;
                end
            end else begin
                rsp_wait--;
            end
        end else if (imem_bus.req_valid) begin
            check("req_addr", imem_bus.addr, model_pc);
            if (ready_wait == 0) begin
                imem_bus.req_ready = 1'b1;
                pending            = 1;
                rsp_wait           = $urandom_range(max_rsp_wait);
                ready_wait         = $urandom_range(max_ready_wait);
                cur_word           = (forced.size() != 0) ? forced.pop_front() : rand_word();
            end else begin
                ready_wait--;
            end
        end
    end

    int          mon_count = 0;
    logic [31:0] chk_pc = '0;
    bit          chk_next = 0;
    bit          halt_seen = 0;
    bit          halt_expected = 0;
    rec_t        rec;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            mon_count     = 0;
            chk_next      = 0;
            halt_seen     = 0;
            halt_expected = 0;
        end else begin
            check("halted_flag", halted, halt_expected);
            check("trap_flag", trap, exp_trap_cyc >= 0 && cyc >= exp_trap_cyc);
            if (halt_expected) begin
                check("halt_state", state, 3'd4);
                check("halt_no_req", imem_bus.req_valid, 1'b0);
                check("halt_pc", pc, chk_pc);
                check("halt_count", instr_count, mon_count);
            end
            if (exp_trap_cyc >= 0 && cyc >= exp_trap_cyc) begin
                check("trap_state", state, 3'd5);
                check("trap_no_req", imem_bus.req_valid, 1'b0);
                check("trap_pc", pc, trap_addr);
                check("trap_count", instr_count, mon_count);
            end
            if (chk_next) begin
                check("pc_after_retire", pc, chk_pc);
                check("count_after_retire", instr_count, mon_count);
                chk_next = 0;
            end
            if (halt_req) halt_seen = 1;
            if (retire) begin
                if (sb.size() == 0) begin
                    check("unexpected_retire", retire, 1'b0);
                end else begin
                    rec = sb.pop_front();
                    check("retire_cycle", cyc, rec.retire_cyc);
                    check("retire_pc", pc, rec.addr);
                    check("retire_instr", instr, rec.word);
                    check("rf_we_wb", rf_we, rec.rf_we);
                    check("count_at_retire", instr_count, mon_count);
                    mon_count++;
                    chk_pc   = rec.addr + 32'd4;
                    chk_next = 1;
                    if (halt_seen) begin
                        halt_expected = 1;
                        halt_seen     = 0;
                    end
                end
            end else begin
                check("rf_we_idle", rf_we, 1'b0);
                if (sb.size() != 0 && cyc > sb[0].retire_cyc) begin
                    check("retire_missing", cyc, sb[0].retire_cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Callers are positioned at a falling edge; reset is held for one rising edge.
    task automatic do_reset();
        rst      = 1'b1;
        halt_req = 1'b0;
        @(negedge clk);
        #3;
        check("rst_state", state, 3'd0);
        check("rst_pc", pc, ResetPc);
        check("rst_addr", imem_bus.addr, ResetPc);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_count", instr_count, 32'd0);
        check("rst_halted", halted, 1'b0);
        check("rst_trap", trap, 1'b0);
        check("rst_req_valid", imem_bus.req_valid, 1'b1);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_retire", retire, 1'b0);
        rst = 1'b0;
    endtask

    task automatic wait_count(input int n, input int budget);
        int b = budget;
        while (mon_count < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("retire_count_reached", mon_count >= n, 1'b1);
    endtask

    task automatic wait_state(input logic [2:0] s, input int min_count, input int budget);
        int b = budget;
        @(negedge clk);
        while (!(state == s && mon_count >= min_count) && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("state_reached", state, s);
    endtask

    task automatic wait_stop(input int budget);
        int b = budget;
        while (!(halted || trap) && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("stopped", halted || trap, 1'b1);
    endtask

    task automatic pulse_halt();
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Zero-wait memory: ADDI x1,x0,5 then ADD x0,x1,x2; pc wraps past 0xFFFF_FFFC.
        max_ready_wait = 0;
        max_rsp_wait   = 0;
        forced.push_back(32'h0050_0093);
        forced.push_back(32'h0020_8033);
        @(negedge clk);
        do_reset();
        wait_count(2, 40);
        @(negedge clk);
        check("wrap_pc", pc, ResetPc + 32'd8);

        // Random request/response latencies, then a halt at a random moment.
        max_ready_wait = 3;
        max_rsp_wait   = 3;
        @(negedge clk);
        do_reset();
        wait_count(25, 1000);
        repeat ($urandom_range(5)) @(negedge clk);
        pulse_halt();
        wait_stop(100);
        repeat (8) @(negedge clk);

        // Halt pulsed in EXEC of the second instruction.
        max_ready_wait = 2;
        max_rsp_wait   = 2;
        do_reset();
        wait_state(3'd2, 1, 100);
        pulse_halt();
        wait_stop(100);
        repeat (5) @(negedge clk);
        check("halt2_count", instr_count, 32'd2);
        check("halt2_pc", pc, ResetPc + 32'd8);

        // Illegal word traps with pc at the faulting fetch.
        max_ready_wait = 1;
        max_rsp_wait   = 1;
        forced.push_back(32'h0050_0093);
        forced.push_back(32'hFFFF_FFFF);
        do_reset();
        wait_stop(100);
        repeat (8) @(negedge clk);
        check("trap_final_count", instr_count, 32'd1);
        check("trap_final_pc", pc, ResetPc + 32'd4);

        // Reset mid-WAIT abandons the fetch; reset in WB suppresses the update.
        max_rsp_wait = 4;
        do_reset();
        wait_state(3'd1, 0, 100);
        do_reset();
        wait_count(3, 200);
        wait_state(3'd3, 3, 100);
        do_reset();
        wait_count(2, 200);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
